xadc_drp_scanner: RTL and testbench
===================================

// Module: xadc_drp_scanner
// PURPOSE
//  Multi-channel XADC DRP read sequencer. Each end-of-conversion starts one scan that
//  reads NUM_CH DRP status registers in order. Optionally averages 2^AVG_LOG2 scans.
//  Publishes per-channel results and flags DRP timeouts. Sits between the XADC primitive
//  DRP port and the register bank (temperature, VCCINT, VCCAUX, ...).
// PARAMETERS
//  NUM_CH       4                           channels per scan (1..8)
//  CH_ADDR      {7'h06,7'h02,7'h01,7'h00}   packed 7b DRP addresses; ch i = CH_ADDR[7*i+:7]
//  DATA_W       12                          result width; sample = drp_do[15 -: DATA_W]
//  AVG_LOG2     2                           average 2^AVG_LOG2 scans; 0 = no averaging
//  TIMEOUT_CYC  255                         max WAIT cycles for drdy (>=2)
// PORTS
//  clk        in   1              system clock
//  rst_n      in   1              reset, asynchronous, active-low
//  eoc_out    in   1              XADC end-of-conversion, level-sampled in IDLE
//  drp_do     in   16             DRP read data
//  drdy       in   1              DRP data ready
//  daddr      out  7              DRP address
//  den        out  1              DRP enable, one-cycle pulse
//  dwe        out  1              DRP write enable, tied 0 (read-only block)
//  di         out  16             DRP write data, tied 0
//  ch_data    out  NUM_CH*DATA_W  results; ch i = ch_data[DATA_W*i+:DATA_W]
//  ch_valid   out  NUM_CH         one-cycle pulse per channel when ch_data updates
//  timeout_err out 1              sticky DRP timeout flag
//  err_clr    in   1              clears timeout_err
// BEHAVIOUR
//  Reset: all outputs, states, indices, counters and accumulators = 0. FSM -> IDLE.
//  All outputs are registered.
//  FSM states: IDLE, ISSUE, WAIT, NEXT.
//   IDLE : eoc_out=1 at the edge -> ISSUE, with ch_idx=0. Otherwise stay.
//   ISSUE: one cycle. den=1, daddr=CH_ADDR[ch_idx], dwe=0 during this cycle.
//          Then -> WAIT, with timer=0.
//   WAIT : drdy=1 -> acc[ch_idx] += drp_do[15-:DATA_W], then -> NEXT.
//          Else timer++. If timer==TIMEOUT_CYC-1 with no drdy -> timeout.
//   NEXT : if ch_idx<NUM_CH-1: ch_idx++ and -> ISSUE.
//          Else: ch_idx=0, scan_cnt++, -> IDLE.
//  Latency: den rises the cycle after eoc_out is sampled in IDLE.
//   With zero-wait drdy, each channel takes 3 cycles (ISSUE, WAIT, NEXT).
//  Publish: on the NEXT cycle where scan_cnt==2^AVG_LOG2-1 and ch_idx==NUM_CH-1:
//   - ch_data[i] = acc[i] >> AVG_LOG2 (truncating) for all i;
//   - ch_valid = all ones for 1 cycle;
//   - acc and scan_cnt cleared (scan_cnt wraps).
//   acc width = DATA_W+AVG_LOG2, so it cannot overflow. AVG_LOG2=0 publishes every scan.
//  Timeout:
//   - timeout_err <= 1;
//   - the scan is aborted: acc and scan_cnt cleared, ch_idx=0, -> IDLE;
//   - ch_data keeps its old value and no ch_valid pulse is issued.
//  Simultaneous events:
//   - drdy on the timeout cycle: drdy wins, no error.
//   - err_clr together with a new timeout: set wins.
//  Ignored inputs:
//   - drdy outside WAIT is ignored (no capture, no error).
//   - eoc_out outside IDLE is ignored, not queued.
//  Reset mid-scan: immediate return to reset values, den drops asynchronously,
//   the partial average is discarded.
//  dwe and di are constant 0 in every state.
// TESTING
//  1. NUM_CH=4, AVG_LOG2=0, eoc pulse; drdy 2 cycles after each den, drp_do=16'hABC0
//     -> daddr sequence 00,01,02,06; 4 den pulses; ch_data all 12'hABC;
//     ch_valid=4'hF once, on the NEXT cycle after the 4th drdy.
//  2. AVG_LOG2=2, ch0 samples 16'h0010,0020,0030,0050 over 4 scans
//     -> ch_data[0]=12'h002 ((1+2+3+5)>>2); no ch_valid before the 4th scan.
//  3. drdy withheld on ch2 -> timeout_err=1 exactly TIMEOUT_CYC cycles after entering WAIT;
//     FSM returns to IDLE; ch_data unchanged; next scan restarts at ch0 with fresh acc.
//  4. drdy asserted on the last WAIT cycle (timer==TIMEOUT_CYC-1) -> sample captured,
//     timeout_err stays 0. err_clr together with a timeout -> timeout_err=1.
//  5. rst_n low during WAIT of ch1 -> den=0, daddr=0, ch_valid=0 immediately.
//     After release, the first eoc starts at ch0 with zero accumulators.
//  6. eoc_out held high for a whole scan, plus stray drdy pulses in IDLE -> scans run back to
//     back only via the IDLE check, and no captures occur outside WAIT.

Source files
------------

// File: rtl/xadc_drp_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xadc_drp_scanner : reads NUM_CH XADC DRP status registers per end-of-conversion
//                    and publishes per-channel results averaged over 2^AVG_LOG2 scans
// Revision: 1.0
// ----------------------------------------------------------------------------
module xadc_drp_scanner #(
  parameter int                    NUM_CH      = 4,
  parameter logic [7*NUM_CH-1:0]   CH_ADDR     = {7'h06, 7'h02, 7'h01, 7'h00},
  parameter int                    DATA_W      = 12,
  parameter int                    AVG_LOG2    = 2,
  parameter int                    TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     eoc_out,
  input  logic [15:0]              drp_do,
  input  logic                     drdy,
  output logic [6:0]               daddr,
  output logic                     den,
  output logic                     dwe,
  output logic [15:0]              di,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam int c_cw = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_aw = DATA_W + AVG_LOG2;
  localparam int c_sw = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int c_tw = $clog2(TIMEOUT_CYC + 1);

  localparam logic [c_tw-1:0] c_timer_last = c_tw'(TIMEOUT_CYC - 1);
  localparam logic [c_sw-1:0] c_scan_last  = c_sw'((1 << AVG_LOG2) - 1);
  localparam logic [c_cw-1:0] c_ch_last    = c_cw'(NUM_CH - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_next  = 2'd3;

  logic [1:0]      r_state;
  logic [c_cw-1:0] r_ch_idx;
  logic [c_tw-1:0] r_timer;
  logic [c_sw-1:0] r_scan_cnt;
  logic [c_aw-1:0] r_acc [NUM_CH];

  logic [DATA_W-1:0]        w_sample;
  logic [c_aw-1:0]          w_acc_sum;
  logic [c_cw-1:0]          w_idx_next;
  logic [6:0]               w_addr_next;
  logic                     w_is_last_ch;
  logic                     w_pub_now;
  logic                     w_timeout;
  logic [c_aw-1:0]          w_pub_full [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] w_pub_data;

  assign w_sample     = drp_do[15 -: DATA_W];
  assign w_acc_sum    = r_acc[r_ch_idx] + c_aw'(w_sample);
  assign w_idx_next   = r_ch_idx + 1'b1;
  assign w_addr_next  = CH_ADDR[7*w_idx_next +: 7];
  assign w_is_last_ch = (r_ch_idx == c_ch_last);
  assign w_pub_now    = (r_state == c_st_wait) && drdy && w_is_last_ch &&
                        (r_scan_cnt == c_scan_last);
  assign w_timeout    = (r_state == c_st_wait) && !drdy && (r_timer == c_timer_last);

  // The last channel's sample is still in flight, so fold it in while publishing.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_pub
      assign w_pub_full[i] = (i == NUM_CH - 1) ? w_acc_sum : r_acc[i];
      assign w_pub_data[DATA_W*i +: DATA_W] = w_pub_full[i][AVG_LOG2 +: DATA_W];
    end
    if (DATA_W < 16) begin : g_lsb
      logic w_unused_lsb;
      assign w_unused_lsb = ^drp_do[15-DATA_W:0];
    end
  endgenerate

  assign dwe = 1'b0;
  assign di  = 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_ch_idx    <= '0;
      r_timer     <= '0;
      r_scan_cnt  <= '0;
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
      daddr       <= '0;
      den         <= 1'b0;
      ch_data     <= '0;
      ch_valid    <= '0;
      timeout_err <= 1'b0;
    end else begin
      den         <= 1'b0;
      ch_valid    <= '0;
      timeout_err <= w_timeout | (timeout_err & ~err_clr);
      case (r_state)
        c_st_idle: begin
          if (eoc_out) begin
            r_state  <= c_st_issue;
            r_ch_idx <= '0;
            den      <= 1'b1;
            daddr    <= CH_ADDR[6:0];
          end
        end
        c_st_issue: begin
          r_state <= c_st_wait;
          r_timer <= '0;
        end
        c_st_wait: begin
          if (drdy) begin
            r_acc[r_ch_idx] <= w_acc_sum;
            r_state         <= c_st_next;
            if (w_pub_now) begin
              ch_data  <= w_pub_data;
              ch_valid <= '1;
            end
          end else if (r_timer == c_timer_last) begin
            r_state    <= c_st_idle;
            r_ch_idx   <= '0;
            r_scan_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        c_st_next: begin
          if (!w_is_last_ch) begin
            r_ch_idx <= w_idx_next;
            r_state  <= c_st_issue;
            den      <= 1'b1;
            daddr    <= w_addr_next;
          end else begin
            r_ch_idx <= '0;
            r_state  <= c_st_idle;
            if (r_scan_cnt == c_scan_last) begin
              r_scan_cnt <= '0;
              for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
            end else begin
              r_scan_cnt <= r_scan_cnt + 1'b1;
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xadc_drp_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_xadc_drp_scanner : bench for xadc_drp_scanner (4-scan averaging and unaveraged copies)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_xadc_drp_scanner;

  localparam int NUM_CH      = 4;
  localparam int DATA_W      = 12;
  localparam int TIMEOUT_CYC = 255;
  localparam int NAVG        = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        eoc_out = 1'b0;
  logic        drdy = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] drp_do = 16'h0000;

  logic [6:0]  daddr, daddr0;
  logic        den, den0, dwe, dwe0, timeout_err, timeout_err0;
  logic [15:0] di, di0;
  logic [NUM_CH*DATA_W-1:0] ch_data, ch_data0;
  logic [NUM_CH-1:0]        ch_valid, ch_valid0;

  xadc_drp_scanner dut (
    .clk(clk), .rst_n(rst_n), .eoc_out(eoc_out), .drp_do(drp_do), .drdy(drdy),
    .daddr(daddr), .den(den), .dwe(dwe), .di(di), .ch_data(ch_data),
    .ch_valid(ch_valid), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  xadc_drp_scanner #(.AVG_LOG2(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .eoc_out(eoc_out), .drp_do(drp_do), .drdy(drdy),
    .daddr(daddr0), .den(den0), .dwe(dwe0), .di(di0), .ch_data(ch_data0),
    .ch_valid(ch_valid0), .timeout_err(timeout_err0), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: running sums per channel, completed-scan count, expected outputs.
  int          acc_m [NUM_CH];
  int          part  [NUM_CH];
  int          n_m;
  logic        err_m;
  logic [47:0] exp_data, exp_data0;

  logic [6:0]  c_addr [NUM_CH] = '{7'h00, 7'h01, 7'h02, 7'h06};
  logic [15:0] t2_ch0 [4]      = '{16'h0010, 16'h0020, 16'h0030, 16'h0050};

  logic [15:0] smp [NUM_CH];
  int          wt  [NUM_CH];
  int          to_ch = -1;
  bit          to_clr = 1'b0;
  bit          hold_eoc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) acc_m[i] = 0;
    n_m = 0;
    err_m = 1'b0;
    exp_data = '0;
    exp_data0 = '0;
  endtask

  task automatic randomize_scan();
    for (int i = 0; i < NUM_CH; i++) begin
      smp[i] = 16'($urandom);
      wt[i]  = $urandom_range(0, 3);
    end
  endtask

  task automatic run_scan();
    bit pub;
    eoc_out = 1'b1;
    tick();
    if (!hold_eoc) eoc_out = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      chk("den_issue", den, 1'b1);
      chk("den0_issue", den0, 1'b1);
      chk("daddr", daddr, c_addr[c]);
      chk("dwe_di", {dwe, di, dwe0, di0}, '0);
      drdy   = 1'($urandom_range(0, 1));
      drp_do = 16'($urandom);
      tick();
      drdy = 1'b0;
      chk("den_wait", den, 1'b0);
      if (c == to_ch) begin
        for (int w = 0; w < TIMEOUT_CYC - 1; w++) tick();
        chk("err_before_timeout", timeout_err, err_m);
        err_clr = to_clr;
        tick();
        err_clr = 1'b0;
        err_m = 1'b1;
        chk("timeout_err", timeout_err, 1'b1);
        chk("timeout_err0", timeout_err0, 1'b1);
        chk("valid_on_timeout", {ch_valid, ch_valid0}, '0);
        chk("data_kept", ch_data, exp_data);
        chk("data0_kept", ch_data0, exp_data0);
        chk("den_after_timeout", den, 1'b0);
        for (int i = 0; i < NUM_CH; i++) acc_m[i] = 0;
        n_m = 0;
        return;
      end
      for (int w = 0; w < wt[c]; w++) tick();
      drdy   = 1'b1;
      drp_do = smp[c];
      tick();
      drdy   = 1'b0;
      drp_do = 16'($urandom);
      part[c] = int'(smp[c]) / 16;
      if (c == NUM_CH - 1) begin
        for (int i = 0; i < NUM_CH; i++) acc_m[i] += part[i];
        n_m++;
        pub = (n_m == NAVG);
        if (pub) begin
          for (int i = 0; i < NUM_CH; i++) begin
            exp_data[12*i +: 12] = 12'(acc_m[i] / NAVG);
            acc_m[i] = 0;
          end
          n_m = 0;
        end
        for (int i = 0; i < NUM_CH; i++) exp_data0[12*i +: 12] = 12'(part[i]);
        chk("ch_valid_last", ch_valid, pub ? 4'hF : 4'h0);
        chk("ch_valid0_last", ch_valid0, 4'hF);
      end else begin
        chk("ch_valid_mid", {ch_valid, ch_valid0}, '0);
      end
      chk("ch_data", ch_data, exp_data);
      chk("ch_data0", ch_data0, exp_data0);
      chk("timeout_err_ok", timeout_err, err_m);
      tick();
    end
    chk("den_idle", den, 1'b0);
    chk("valid_idle", {ch_valid, ch_valid0}, '0);
  endtask

  task automatic stray_drdy();
    for (int k = 0; k < 3; k++) begin
      drdy   = 1'b1;
      drp_do = 16'($urandom);
      tick();
      drdy = 1'b0;
      chk("stray_den", {den, den0}, '0);
      chk("stray_valid", {ch_valid, ch_valid0}, '0);
    end
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_den", {den, den0}, '0);
    chk("rst_daddr", {daddr, daddr0}, '0);
    chk("rst_valid", {ch_valid, ch_valid0}, '0);
    chk("rst_data", ch_data, '0);
    chk("rst_data0", ch_data0, '0);
    chk("rst_err", {timeout_err, timeout_err0}, '0);
    rst_n = 1'b1;
    tick();

    // Constant sample, drdy two cycles after den
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < NUM_CH; i++) begin smp[i] = 16'hABC0; wt[i] = 1; end
      run_scan();
      chk("t1_data0", ch_data0, {4{12'hABC}});
    end
    chk("t1_data", ch_data, {4{12'hABC}});

    // Averaging of directed ch0 samples
    for (int s = 0; s < 4; s++) begin
      randomize_scan();
      smp[0] = t2_ch0[s];
      run_scan();
    end
    chk("t2_avg_ch0", ch_data[11:0], 12'h002);

    // Random scans with stray drdy while idle
    for (int s = 0; s < 6; s++) begin
      randomize_scan();
      run_scan();
      stray_drdy();
    end

    // Timeout on ch2 with err_clr in the same cycle
    randomize_scan();
    to_ch = 2; to_clr = 1'b1;
    run_scan();
    to_ch = -1; to_clr = 1'b0;
    stray_drdy();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    err_m = 1'b0;
    chk("err_clr", {timeout_err, timeout_err0}, '0);
    for (int s = 0; s < 4; s++) begin
      randomize_scan();
      run_scan();
    end

    // drdy on the last permissible WAIT cycle
    randomize_scan();
    wt[1] = TIMEOUT_CYC - 1;
    run_scan();
    chk("late_drdy_no_err", {timeout_err, timeout_err0}, '0);

    // eoc held high: scans restart only from IDLE
    hold_eoc = 1'b1;
    for (int s = 0; s < 3; s++) begin
      randomize_scan();
      run_scan();
    end
    hold_eoc = 1'b0;
    eoc_out = 1'b0;
    tick();
    chk("eoc_released_idle", {den, den0}, '0);

    // Reset during WAIT of ch1
    eoc_out = 1'b1;
    tick();
    eoc_out = 1'b0;
    tick();
    drdy = 1'b1; drp_do = 16'($urandom);
    tick();
    drdy = 1'b0;
    tick();
    chk("t5_daddr_ch1", daddr, 7'h01);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_den", {den, den0}, '0);
    chk("t5_daddr", {daddr, daddr0}, '0);
    chk("t5_valid", {ch_valid, ch_valid0}, '0);
    chk("t5_data", {ch_data, ch_data0}, '0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) begin
      randomize_scan();
      run_scan();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
